// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch queue between a combinational instruction
// ROM and the Decode stage.
//
// Each cycle in which the queue has room (or frees a slot through a pop),
// the word at fetch_pc is captured together with its PC and fetch_pc steps
// by 4. Decode sees the oldest entry on instr_out/pc_out. A redirect (flush)
// empties the queue and reloads fetch_pc from redirect_pc.
//
// Handshake: instr_valid is the producer-side valid and ~stall is the
// consumer-side ready. An entry is consumed on a rising edge exactly when
// instr_valid=1, stall=0 and flush=0. While stall=1 the head entry and every
// output derived from it stay stable. flush overrides both sides.
//
// Build option: define FETCH_BUFFER_BYPASS_EN to forward the ROM word
// straight to the outputs while the queue is empty (zero-latency fetch).
// Without it, a fetched word always passes through the queue (one-cycle
// latency).

module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [31:0]               redirect_pc,
    input  logic                      stall,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_data,
    output logic                      instr_valid,
    output logic [31:0]               instr_out,
    output logic [31:0]               pc_out,
    output logic [31:0]               pc_plus4_out,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Architectural state
    logic [31:0]      fetchPc;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] occupancy;

    // Entry storage; never reset, the outputs are gated by occupancy instead
    logic [31:0]      instrMem [DEPTH];
    logic [31:0]      pcMem    [DEPTH];

    // Per-cycle control
    logic             queueEmpty;
    logic             queueFull;
    logic             queuePop;
    logic             queuePush;
    logic             bypassTake;
    logic             fetchAdvance;
    logic             storeEn;

    // Head entry as read from storage
    logic [31:0]      headInstr;
    logic [31:0]      headPc;

    // Push/pop decision for this cycle; flush suppresses both
    always_comb begin
        queueEmpty = (occupancy == '0);
        queueFull  = (occupancy == FULL_COUNT);
        queuePop   = ~queueEmpty & ~stall & ~flush;
`ifdef FETCH_BUFFER_BYPASS_EN
        // Empty queue and Decode ready: the ROM word goes straight out and
        // is not stored. With stall=1 the word is stored normally, so the
        // same entry is presented from the queue on the following cycle.
        bypassTake = queueEmpty & ~flush & ~stall;
`else
        bypassTake = 1'b0;
`endif
        queuePush    = ~flush & (~queueFull | queuePop) & ~bypassTake;
        fetchAdvance = queuePush | bypassTake;
        storeEn      = queuePush & ~reset;
    end

    // Fetch PC, pointers and occupancy; reset beats flush, flush beats all
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc   <= RESET_PC;
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else if (flush) begin
            fetchPc   <= redirect_pc;
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else begin
            if (fetchAdvance) begin
                fetchPc <= fetchPc + 32'd4;
            end
            if (queuePush) begin
                tailPtr <= tailPtr + PTR_ONE;
            end
            if (queuePop) begin
                headPtr <= headPtr + PTR_ONE;
            end
            // Push and pop together leave occupancy unchanged, even when full
            case ({queuePush, queuePop})
                2'b10:   occupancy <= occupancy + CNT_ONE;
                2'b01:   occupancy <= occupancy - CNT_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Capture {fetch_pc, ROM word} at the tail on every push
    always_ff @(posedge clk) begin
        if (storeEn) begin
            instrMem[tailPtr] <= imem_data;
            pcMem[tailPtr]    <= fetchPc;
        end
    end

    // Head read, zeroed when the queue is empty (optionally bypassed)
    always_comb begin
        headInstr   = instrMem[headPtr];
        headPc      = pcMem[headPtr];
        instr_valid = ~queueEmpty;
        instr_out   = queueEmpty ? 32'h0 : headInstr;
        pc_out      = queueEmpty ? 32'h0 : headPc;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (queueEmpty && !flush && !reset) begin
            instr_valid = 1'b1;
            instr_out   = imem_data;
            pc_out      = fetchPc;
        end
`endif
        pc_plus4_out = pc_out + 32'd4;
    end

    // Plain output mapping of internal state
    always_comb begin
        imem_addr = fetchPc;
        count     = occupancy;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed bench for fetch_buffer (DEPTH=4, RESET_PC=0).
// The ROM returns address ^ romKey so instruction words and PCs differ
// whenever romKey is non-zero. Built with FETCH_BUFFER_BYPASS_EN the bench
// runs the zero-latency sequence instead of the queued-latency sequence.

module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hCAFE_0000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] redirectPc;
    logic        stall;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4Out;
    logic [2:0]  count;
    logic [31:0] romKey;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .redirect_pc  (redirectPc),
        .stall        (stall),
        .imem_addr    (imemAddr),
        .imem_data    (imemData),
        .instr_valid  (instrValid),
        .instr_out    (instrOut),
        .pc_out       (pcOut),
        .pc_plus4_out (pcPlus4Out),
        .count        (count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM
    assign imemData = imemAddr ^ romKey;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        redirectPc = 32'h0;
        stall      = 1'b0;
        romKey     = 32'h0;
        #2;
        check("rst_addr",  imemAddr, RESET_PC);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(instrValid), 32'd0);

`ifndef FETCH_BUFFER_BYPASS_EN
        check("rst_instr", instrOut, 32'd0);
        check("rst_pc",    pcOut, 32'd0);
        check("rst_pc4",   pcPlus4Out, 32'd4);

        // Streaming from reset, no stall: one instruction per edge
        tick();
        reset = 1'b0;
        check("s1_pre_valid", 32'(instrValid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("s1_pc",    pcOut, 32'(4 * i));
            check("s1_instr", instrOut, 32'(4 * i));
            check("s1_valid", 32'(instrValid), 32'd1);
            check("s1_count", 32'(count), 32'd1);
            check("s1_addr",  imemAddr, 32'(4 * (i + 1)));
        end

        // Stall from reset: fill to DEPTH, then hold
        reset  = 1'b1;
        stall  = 1'b1;
        romKey = KEY;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s2_fill_count", 32'(count), 32'(i + 1));
        end
        check("s2_addr_full", imemAddr, 32'd16);
        check("s2_head_pc",   pcOut, 32'd0);
        check("s2_head_ins",  instrOut, KEY);
        tick();
        check("s2_hold_count", 32'(count), 32'd4);
        check("s2_hold_addr",  imemAddr, 32'd16);
        check("s2_hold_pc",    pcOut, 32'd0);

        // Full buffer, stall dropped for a single cycle
        stall = 1'b0;
        tick();
        stall = 1'b1;
        check("s3_count", 32'(count), 32'd4);
        check("s3_pc",    pcOut, 32'd4);
        check("s3_instr", instrOut, 32'd4 ^ KEY);
        check("s3_addr",  imemAddr, 32'd20);
        tick();
        check("s3_stable_pc",    pcOut, 32'd4);
        check("s3_stable_instr", instrOut, 32'd4 ^ KEY);
        check("s3_stable_addr",  imemAddr, 32'd20);

        // Release stall: remaining queued entries drain back to back
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s2_drain_pc",    pcOut, 32'(8 + 4 * i));
            check("s2_drain_count", 32'(count), 32'd4);
        end

        // Flush while count=3 under stall
        reset = 1'b1;
        stall = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("s4_pre_count", 32'(count), 32'd3);
        flush      = 1'b1;
        redirectPc = 32'h0000_0100;
        tick();
        flush = 1'b0;
        check("s4_count", 32'(count), 32'd0);
        check("s4_valid", 32'(instrValid), 32'd0);
        check("s4_addr",  imemAddr, 32'h100);
        check("s4_pc0",   pcOut, 32'd0);
        tick();
        check("s4_pc",    pcOut, 32'h100);
        check("s4_instr", instrOut, 32'h100 ^ KEY);
        check("s4_pc4",   pcPlus4Out, 32'h104);
        check("s4_valid1", 32'(instrValid), 32'd1);

        // Asynchronous reset mid-cycle with count=2, flush pending too
        tick();
        check("s5_pre_count", 32'(count), 32'd2);
        #3;
        reset      = 1'b1;
        flush      = 1'b1;
        redirectPc = 32'h0000_0200;
        #1;
        check("s5_async_valid", 32'(instrValid), 32'd0);
        check("s5_async_count", 32'(count), 32'd0);
        check("s5_async_addr",  imemAddr, RESET_PC);
        tick();
        check("s5_prio_addr", imemAddr, RESET_PC);
        reset = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        tick();
        check("s5_first_pc",    pcOut, 32'd0);
        check("s5_first_count", 32'(count), 32'd1);

        // PC wrap from 32'hFFFF_FFFC
        stall      = 1'b1;
        flush      = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        check("s6_addr", imemAddr, 32'hFFFF_FFFC);
        tick();
        check("s6_count1", 32'(count), 32'd1);
        check("s6_addr_wrap", imemAddr, 32'd0);
        check("s6_pc_top", pcOut, 32'hFFFF_FFFC);
        check("s6_pc4_top", pcPlus4Out, 32'd0);
        tick();
        check("s6_count2", 32'(count), 32'd2);
        stall = 1'b0;
        tick();
        check("s6_pc_wrap", pcOut, 32'd0);
        check("s6_ins_wrap", instrOut, KEY);
        check("s6_pc4_wrap", pcPlus4Out, 32'd4);
        check("s6_count", 32'(count), 32'd2);
`else
        // Zero-latency bypass sequence
        romKey = KEY;
        tick();
        reset = 1'b0;
        check("b_valid", 32'(instrValid), 32'd1);
        check("b_pc",    pcOut, 32'd0);
        check("b_instr", instrOut, KEY);
        check("b_count", 32'(count), 32'd0);
        tick();
        check("b_pc1",    pcOut, 32'd4);
        check("b_count1", 32'(count), 32'd0);
        check("b_addr1",  imemAddr, 32'd4);
        tick();
        check("b_pc2", pcOut, 32'd8);
        stall = 1'b1;
        tick();
        check("b_stall_count", 32'(count), 32'd1);
        check("b_stall_pc",    pcOut, 32'd8);
        check("b_stall_addr",  imemAddr, 32'd12);
        flush      = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        tick();
        check("b_flush_valid", 32'(instrValid), 32'd0);
        flush = 1'b0;
        #1;
        check("b_wrap_valid", 32'(instrValid), 32'd1);
        check("b_wrap_pc",    pcOut, 32'hFFFF_FFFC);
        check("b_wrap_pc4",   pcPlus4Out, 32'd0);
        tick();
        check("b_wrap_count", 32'(count), 32'd1);
        check("b_wrap_addr",  imemAddr, 32'd0);
        stall = 1'b0;
        tick();
        check("b_after_pc",    pcOut, 32'd0);
        check("b_after_count", 32'(count), 32'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
